// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer. The input goes to output {s2,s1,s0} and every other output is zero.
// The outputs are registered by default. Set REGISTERED=0 to get a purely combinational path.

module demux_1to8_lane #(
  parameter int unsigned DATA_W     = 1,
  parameter int unsigned LANE       = 0,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_sel,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_out
);
  logic [DATA_W-1:0] w_dec;

  assign w_dec = (i_sel == 3'(LANE)) ? i_in : '0;

  generate
    if (REGISTERED) begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= w_dec;
      end
      assign o_out = r_q;
    end else begin : g_comb
      // clk/rst have no role in the combinational variant
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_out    = w_dec;
    end
  endgenerate
endmodule

module demux_1to8 #(
  parameter int unsigned DATA_W     = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              s0,
  input  logic              s1,
  input  logic              s2,
  output logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] d4,
  output logic [DATA_W-1:0] d5,
  output logic [DATA_W-1:0] d6,
  output logic [DATA_W-1:0] d7
);
  localparam int unsigned NUM_LANES = 8;

  logic [2:0]                        w_sel;
  logic [NUM_LANES-1:0][DATA_W-1:0]  w_out;

  assign w_sel = {s2, s1, s0};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      demux_1to8_lane #(
        .DATA_W     (DATA_W),
        .LANE       (g),
        .REGISTERED (REGISTERED)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .i_sel (w_sel),
        .i_in  (in),
        .o_out (w_out[g])
      );
    end
  endgenerate

  assign d0 = w_out[0];
  assign d1 = w_out[1];
  assign d2 = w_out[2];
  assign d3 = w_out[3];
  assign d4 = w_out[4];
  assign d5 = w_out[5];
  assign d6 = w_out[6];
  assign d7 = w_out[7];
endmodule

// File: tb/tb_demux_1to8.sv
// Bench for demux_1to8. It covers three builds: the 1-bit registered default, an 8-bit registered build
// and an 8-bit combinational build.
// Directed vectors drive the inputs. A per-cycle model compare runs alongside a set of literal checks.

module tb_demux_1to8;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in1 = 1'b0;
  logic [7:0] in8 = 8'h00;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic       started = 1'b0;
  int         total = 0;
  int         bad = 0;

  wire [7:0]      o1;
  wire [7:0][7:0] o8;
  wire [7:0][7:0] oc;

  always #5 clk = ~clk;

  demux_1to8 #(.DATA_W(1), .REGISTERED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .s0(s0), .s1(s1), .s2(s2),
    .d0(o1[0]), .d1(o1[1]), .d2(o1[2]), .d3(o1[3]),
    .d4(o1[4]), .d5(o1[5]), .d6(o1[6]), .d7(o1[7])
  );

  demux_1to8 #(.DATA_W(8), .REGISTERED(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .s0(s0), .s1(s1), .s2(s2),
    .d0(o8[0]), .d1(o8[1]), .d2(o8[2]), .d3(o8[3]),
    .d4(o8[4]), .d5(o8[5]), .d6(o8[6]), .d7(o8[7])
  );

  demux_1to8 #(.DATA_W(8), .REGISTERED(1'b0)) dutc (
    .clk(clk), .rst(rst), .in(in8), .s0(s0), .s1(s1), .s2(s2),
    .d0(oc[0]), .d1(oc[1]), .d2(oc[2]), .d3(oc[3]),
    .d4(oc[4]), .d5(oc[5]), .d6(oc[6]), .d7(oc[7])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic i1, input logic [7:0] i8);
    {s2, s1, s0} = 3'(sel);
    in1 = i1;
    in8 = i8;
  endtask

  // Model: the registered outputs show what was last sampled at an edge. Reset behaves as sampling in=0.
  logic       m_in1 = 1'b0;
  logic [7:0] m_in8 = 8'h00;
  logic [2:0] m_sel = 3'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in1 = 1'b0;
      m_in8 = 8'h00;
      m_sel = 3'd0;
    end else begin
      m_in1 = in1;
      m_in8 = in8;
      m_sel = {s2, s1, s0};
    end
  end

  always @(negedge clk) begin
    logic [7:0]      e1;
    logic [7:0][7:0] e8, ec;
    if (started) begin
      for (int k = 0; k < 8; k++) begin
        e1[k] = (k == int'(m_sel)) ? m_in1 : 1'b0;
        e8[k] = (k == int'(m_sel)) ? m_in8 : 8'h00;
        ec[k] = (k == int'({s2, s1, s0})) ? in8 : 8'h00;
      end
      check("cyc_d1", 64'(o1), 64'(e1));
      check("cyc_d8", o8, e8);
      check("cyc_comb", oc, ec);
    end
  end

  initial begin
    // Reset is applied before the first edge at t=5.
    drive(5, 1'b1, 8'h3C);
    #1 rst = 1'b1;
    #1;
    started = 1'b1;
    check("rst_async_d1", 64'(o1), 64'h0);
    check("rst_async_d8", o8, 64'h0);
    check("rst_comb_d5", oc, 64'h0000_3C00_0000_0000);
    repeat (3) @(posedge clk);
    #2 check("rst_hold_d1", 64'(o1), 64'h0);

    // Idle: in=0, sel=0
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    @(posedge clk); #2;
    check("idle", 64'(o1), 64'h0);

    // Basic route to sel=2. The old value must hold until the edge.
    drive(2, 1'b1, 8'h01);
    #1 check("basic_pre", 64'(o1), 64'h0);
    @(posedge clk); #1;
    check("basic_post", 64'(o1), 64'h04);

    // Sweep with in=1, then with in=0.
    for (int s = 0; s < 8; s++) begin
      drive(s, 1'b1, 8'h5A);
      @(posedge clk); #2;
      check("sweep1", 64'(o1), 64'(8'(1) << s));
    end
    for (int s = 0; s < 8; s++) begin
      drive(s, 1'b0, 8'h00);
      @(posedge clk); #2;
      check("sweep0", 64'(o1), 64'h0);
      check("sweep0_d8", o8, 64'h0);
    end

    // Assert reset between edges while d7 is driven.
    drive(7, 1'b1, 8'hFF);
    @(posedge clk); #2;
    check("mid_d7", 64'(o1), 64'h80);
    #1 rst = 1'b1;
    #1 check("mid_rst_d1", 64'(o1), 64'h0);
    check("mid_rst_d8", o8, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    check("mid_rst_held", 64'(o1), 64'h0);
    @(posedge clk); #2;
    check("mid_recover", 64'(o1), 64'h80);

    // 8-bit registered build: 0xA5 to sel=6.
    drive(6, 1'b0, 8'hA5);
    @(posedge clk); #2;
    check("w8_sel6", o8, 64'h00A5_0000_0000_0000);

    // Combinational build: the output changes with no clock edge.
    drive(3, 1'b1, 8'h01);
    #1 check("comb_sel3", oc, 64'h0000_0000_0100_0000);
    @(posedge clk); #2;
    check("w8_sel3", o8, 64'h0000_0000_0100_0000);
    @(posedge clk); #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
